// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32 execute-stage types for the M-extension sequencer
// Purpose: operation and FSM state encodings used by muldiv_seq and muldiv_step.
// Ports: none (package).
package rv32i_types;

    // Encoded exactly as the RV32M funct3 field.
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } muldiv_state_t;

    // Loaded into the step counter in PREP; ITER runs last_step+1 cycles.
    localparam logic [4:0] LAST_STEP = 5'd31;

    // funct3[2] separates the divide family from the multiply family.
    function automatic logic is_div_op(input muldiv_op_t op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 shift-add multiply or restoring-divide iteration
// Purpose: purely combinational single iteration shared by both operation families.
// Ports:
//   div_mode         1 = restoring divide step, 0 = shift-add multiply step
//   hi, lo           current {hi, lo} product or {r, q} remainder/quotient
//   operand          multiplicand (multiply) or divisor (divide)
//   hi_next, lo_next register values after this iteration
module muldiv_step
    import rv32i_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic            div_mode,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] rem_shift;
    logic [XLEN:0] diff;

    always_comb begin
        // Multiply: 33-bit add keeps the carry that shifts into hi[XLEN-1].
        sum       = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
        // Divide: {r, q} << 1, with the remainder widened so the trial
        // subtract sign bit is exact.
        rem_shift = {hi, lo[XLEN-1]};
        diff      = rem_shift - {1'b0, operand};

        hi_next = hi;
        lo_next = lo;
        if (div_mode) begin
            if (!diff[XLEN]) begin
                hi_next = diff[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_next = rem_shift[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_next = sum[XLEN:1];
            lo_next = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M multiply/divide sequencer with valid/ready handshakes
// Purpose: accepts one MUL..REMU op, runs 32 muldiv_step iterations, returns one result.
// Optional feature macro: MULDIV_EARLY_OUT_EN (zero-operand results issued one cycle
// after accept instead of after the full loop).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   flush                         abort any in-flight operation, no response
//   req_valid/req_ready           request handshake; req_op (funct3), req_a, req_b
//   resp_valid/resp_ready         response handshake; resp_data result
module muldiv_seq
    import rv32i_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data
);

    muldiv_state_t   state;
    muldiv_op_t      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;      // raw rs2 at accept, then |b| (multiplicand/divisor)
    logic [XLEN-1:0] hi;     // product high half / remainder
    logic [XLEN-1:0] lo;     // product low half / quotient
    logic            neg;    // final result needs two's-complement negation
    logic [4:0]      count;

    logic [XLEN-1:0] hi_next;
    logic [XLEN-1:0] lo_next;

    logic            sign_a;
    logic            sign_b;
    logic            neg_prep;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] mul_hi_neg;
    logic [XLEN-1:0] fix_result;

    assign req_ready = (state == ST_IDLE) && !flush && !rst;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .div_mode (is_div_op(op)),
        .hi       (hi),
        .lo       (lo),
        .operand  (b),
        .hi_next  (hi_next),
        .lo_next  (lo_next)
    );

    // Sign capture and magnitude conversion, consumed in PREP.
    always_comb begin
        sign_a   = a[XLEN-1] && (op == OP_MULH || op == OP_MULHSU ||
                                 op == OP_DIV  || op == OP_REM);
        sign_b   = b[XLEN-1] && (op == OP_MULH || op == OP_DIV || op == OP_REM);
        a_mag    = sign_a ? (~a + 1'b1) : a;
        b_mag    = sign_b ? (~b + 1'b1) : b;
        neg_prep = 1'b0;
        case (op)
            OP_MULH, OP_MULHSU: neg_prep = sign_a ^ sign_b;
            // A zero divisor keeps the all-ones quotient unsigned-looking.
            OP_DIV:             neg_prep = (sign_a ^ sign_b) && (b != '0);
            OP_REM:             neg_prep = sign_a;
            default:            neg_prep = 1'b0;
        endcase
    end

    // High half of -{hi, lo}: the +1 only carries into hi when lo is zero.
    always_comb begin
        mul_hi_neg = ~hi + {{(XLEN-1){1'b0}}, (lo == '0)};
        fix_result = lo;
        case (op)
            OP_MUL:                       fix_result = lo;
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = neg ? mul_hi_neg : hi;
            OP_DIV, OP_DIVU:              fix_result = neg ? (~lo + 1'b1) : lo;
            default:                      fix_result = neg ? (~hi + 1'b1) : hi;
        endcase
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic            early_hit;
    logic [XLEN-1:0] early_result;

    // These are exactly what the full loop would produce for the same inputs.
    always_comb begin
        if (req_op[2]) begin
            early_hit    = (req_b == '0);
            early_result = req_op[1] ? req_a : {XLEN{1'b1}};
        end else begin
            early_hit    = (req_a == '0) || (req_b == '0);
            early_result = '0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            op         <= OP_MUL;
            a          <= '0;
            b          <= '0;
            hi         <= '0;
            lo         <= '0;
            neg        <= 1'b0;
            count      <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else if (flush) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op <= muldiv_op_t'(req_op);
                        a  <= req_a;
                        b  <= req_b;
`ifdef MULDIV_EARLY_OUT_EN
                        if (early_hit) begin
                            resp_data  <= early_result;
                            resp_valid <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            state <= ST_PREP;
                        end
`else
                        state <= ST_PREP;
`endif
                    end
                end
                ST_PREP: begin
                    neg   <= neg_prep;
                    hi    <= '0;
                    lo    <= a_mag;
                    b     <= b_mag;
                    count <= LAST_STEP;
                    state <= ST_ITER;
                end
                ST_ITER: begin
                    hi <= hi_next;
                    lo <= lo_next;
                    if (count == '0) begin
                        state <= ST_FIX;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                ST_FIX: begin
                    resp_data  <= fix_result;
                    resp_valid <= 1'b1;
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed self-checking bench for muldiv_seq
module tb_muldiv_seq;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;

    int checks = 0;
    int errors = 0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 35;
`endif

    muldiv_seq #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents a request in IDLE; returns in cycle E+1.
    task automatic issue(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        check({tag, " req_ready idle"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        step();
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
    endtask

    // Bounded wait for resp_valid; lat counts cycles from the accept edge.
    task automatic wait_resp(output int lat, output logic ready_leak);
        lat        = 1;
        ready_leak = 1'b0;
        while (!resp_valid && lat < 100) begin
            if (req_ready) ready_leak = 1'b1;
            step();
            lat++;
        end
        if (req_ready) ready_leak = 1'b1;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_data, input int exp_lat);
        int   lat;
        logic leak;
        issue(tag, op, a, b);
        wait_resp(lat, leak);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " data"}, resp_data, exp_data);
        check({tag, " req_ready busy"}, {31'b0, leak}, 32'd0);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check({tag, " resp_valid after hs"}, {31'b0, resp_valid}, 32'd0);
        check({tag, " req_ready after hs"}, {31'b0, req_ready}, 32'd1);
    endtask

    task automatic no_pulse(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (resp_valid) seen = 1'b1;
        end
        check({tag, " no resp pulse"}, {31'b0, seen}, 32'd0);
    endtask

    initial begin
        int          lat;
        logic        leak;
        logic [31:0] held;

        // Reset
        step();
        check("reset req_ready", {31'b0, req_ready}, 32'd0);
        check("reset resp_valid", {31'b0, resp_valid}, 32'd0);
        check("reset resp_data", resp_data, 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("post-reset req_ready", {31'b0, req_ready}, 32'd1);

        // Main function
        run_op("mul 7*6",        OP_MUL,    32'd7,        32'd6,        32'h0000002A, 35);
        run_op("mul -2*3",       OP_MUL,    32'hFFFFFFFE, 32'd3,        32'hFFFFFFFA, 35);
        run_op("mulh min*min",   OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 35);
        run_op("mulh -2*3",      OP_MULH,   32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 35);
        run_op("mulhsu -1*max",  OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 35);
        run_op("mulhu max*max",  OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35);
        run_op("div -7/2",       OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 35);
        run_op("rem -7%2",       OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 35);
        run_op("div 7/-2",       OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 35);
        run_op("rem 7%-2",       OP_REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, 35);
        run_op("divu 100/7",     OP_DIVU,   32'd100,      32'd7,        32'd14,       35);
        run_op("remu 100%7",     OP_REMU,   32'd100,      32'd7,        32'd2,        35);
        run_op("div ovf",        OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 35);
        run_op("rem ovf",        OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 35);

        // Zero-operand corners (early-out candidates)
        run_op("divu 5/0",       OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, ZERO_LAT);
        run_op("remu 5/0",       OP_REMU,   32'd5,        32'd0,        32'd5,        ZERO_LAT);
        run_op("div -5/0",       OP_DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, ZERO_LAT);
        run_op("rem -5/0",       OP_REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, ZERO_LAT);
        run_op("mul 0*9",        OP_MUL,    32'd0,        32'd9,        32'd0,        ZERO_LAT);
        run_op("mulhu 9*0",      OP_MULHU,  32'd9,        32'd0,        32'd0,        ZERO_LAT);

        // Back-pressure in DONE
        issue("hold", OP_DIVU, 32'd100, 32'd7);
        wait_resp(lat, leak);
        check("hold latency", lat, 35);
        held = resp_data;
        check("hold data", held, 32'd14);
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold resp_valid", {31'b0, resp_valid}, 32'd1);
            check("hold resp_data", resp_data, 32'd14);
            check("hold req_ready", {31'b0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("hold release resp_valid", {31'b0, resp_valid}, 32'd0);
        check("hold release req_ready", {31'b0, req_ready}, 32'd1);
        run_op("after hold", OP_MUL, 32'd12, 32'd12, 32'd144, 35);

        // Flush at E+10
        issue("flush", OP_MUL, 32'd7, 32'd6);
        repeat (9) step();
        flush = 1'b1;
        #1;
        check("flush req_ready low", {31'b0, req_ready}, 32'd0);
        step();
        flush = 1'b0;
        #1;
        check("flush idle req_ready", {31'b0, req_ready}, 32'd1);
        check("flush resp_valid", {31'b0, resp_valid}, 32'd0);
        no_pulse("flush", 40);
        run_op("after flush", OP_MUL, 32'd7, 32'd6, 32'h0000002A, 35);

        // Reset at E+20
        issue("reset mid", OP_DIV, 32'hFFFFFFF9, 32'd2);
        repeat (19) step();
        rst = 1'b1;
        step();
        check("mid reset req_ready", {31'b0, req_ready}, 32'd0);
        check("mid reset resp_valid", {31'b0, resp_valid}, 32'd0);
        check("mid reset resp_data", resp_data, 32'd0);
        rst = 1'b0;
        #1;
        check("after reset req_ready", {31'b0, req_ready}, 32'd1);
        no_pulse("reset mid", 40);
        run_op("after reset", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 35);

        // Flush beats accept in IDLE
        flush     = 1'b1;
        req_valid = 1'b1;
        req_op    = OP_MUL;
        req_a     = 32'd3;
        req_b     = 32'd4;
        #1;
        check("flush idle req_ready", {31'b0, req_ready}, 32'd0);
        step();
        flush     = 1'b0;
        req_valid = 1'b0;
        #1;
        check("flush idle not accepted", {31'b0, req_ready}, 32'd1);
        no_pulse("flush idle", 40);
        run_op("after idle flush", OP_MUL, 32'd3, 32'd4, 32'd12, 35);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
